// File: rtl/spi_pkg.sv
// Shared definitions for the SPI stash block: byte width and stash FSM states.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider producing a one-cycle SCLK_PULSE strobe every CLK_DIV clocks.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CTRL_CLK,
  input  logic NRST,
  output logic SCLK_PULSE
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

  logic [CW-1:0] cnt;

  // Strobe is registered, so it is raised one count early to land on CNT_LAST.
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      cnt        <= '0;
      SCLK_PULSE <= 1'b0;
    end else begin
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      SCLK_PULSE <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/spi_stash.sv
// TX/RX byte stash sequencing one SPI master transfer and capturing returned bytes.
module spi_stash
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              CTRL_CLK,
  input  logic              NRST,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [BYTE_W-1:0] WR_DATA,
  input  logic [AW-1:0]     RD_ADDR,
  output logic [BYTE_W-1:0] RD_DATA,
  input  logic              START,
  input  logic [AW:0]       LEN,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic [AW:0]       RX_COUNT,
  output logic              SCLK_PULSE,
  output logic              XFER_N,
  output logic [BYTE_W-1:0] MOSI_data,
  input  logic [BYTE_W-1:0] MISO_data,
  input  logic [BYTE_W-1:0] stash_ptr
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [BYTE_W-1:0] tx_mem [DEPTH];
  logic [BYTE_W-1:0] rx_mem [DEPTH];
  logic [BYTE_W-1:0] ptr_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     cnt_inc_c;
  logic              byte_evt_c;
  logic              accept_c;
  logic              store_c;
  logic              finish_c;

  // Any change of the master's byte counter, including 255->0, marks a finished byte.
  assign byte_evt_c = (stash_ptr != ptr_q);
  assign cnt_inc_c  = RX_COUNT + CW'(1);

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    store_c   = 1'b0;
    finish_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START && !ABORT && (LEN != '0)) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        store_c = byte_evt_c;
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else if (byte_evt_c && (cnt_inc_c == len_q)) begin
          finish_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      ptr_q     <= stash_ptr;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      XFER_N    <= 1'b1;
      MOSI_data <= '0;
      RX_COUNT  <= '0;
      RD_DATA   <= '0;
      len_q     <= '0;
    end else begin
      ptr_q   <= stash_ptr;
      DONE    <= finish_c;
      RD_DATA <= rx_mem[RD_ADDR];
      if (accept_c) begin
        RX_COUNT  <= '0;
        MOSI_data <= tx_mem[AW'(0)];
        XFER_N    <= 1'b0;
        BUSY      <= 1'b1;
        len_q     <= (LEN > DEPTH_C) ? DEPTH_C : LEN;
      end else if (state == ST_RUN) begin
        if (store_c) begin
          RX_COUNT  <= cnt_inc_c;
          MOSI_data <= tx_mem[cnt_inc_c[AW-1:0]];
        end
        if (ABORT || finish_c) begin
          XFER_N <= 1'b1;
          BUSY   <= 1'b0;
        end
      end
    end
  end

  // Stash arrays carry no reset; the TX side is frozen while a transfer runs.
  always_ff @(posedge CTRL_CLK) begin
    if (NRST && WR_EN && (state == ST_IDLE)) tx_mem[WR_ADDR] <= WR_DATA;
    if (NRST && store_c) rx_mem[RX_COUNT[AW-1:0]] <= MISO_data;
  end

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .CTRL_CLK  (CTRL_CLK),
    .NRST      (NRST),
    .SCLK_PULSE(SCLK_PULSE)
  );

endmodule
